// File: rtl/tpu_ctrl_pkg.sv
// Shared control definitions for the systolic-array FIFO load/drain scheduler.
// Holds the controller state encoding, default geometry and counter-width helpers.
package tpu_ctrl_pkg;

  localparam int DIM_DEF   = 8;
  localparam int DEPTH_DEF = 8;
  localparam int BITS_DEF  = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Width of a counter that must hold values 0..n-1 (at least one bit).
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int ROW_W_DEF = cnt_w(DIM_DEF);
  localparam int T_W_DEF   = cnt_w(DEPTH_DEF + DIM_DEF - 1);

endpackage

// File: rtl/skew_window.sv
// Decodes the drain counter into the skewed pop window: FIFO i pops while
// i <= t <= i+DEPTH-1, giving the diagonal wavefront the systolic array expects.
module skew_window #(
  parameter int DIM   = 8,
  parameter int DEPTH = 8,
  parameter int T_W   = 4
) (
  input  logic [T_W-1:0] t,
  input  logic           en,
  output logic [DIM-1:0] win
);

  for (genvar i = 0; i < DIM; i++) begin : g_lane
    localparam logic [T_W:0] HI = (T_W+1)'(i + DEPTH - 1);
    logic lo_ok;
    logic hi_ok;

    // Lane 0 has no lower bound; skipping the compare avoids a constant-true test.
    if (i == 0) begin : g_first
      assign lo_ok = 1'b1;
    end else begin : g_rest
      localparam logic [T_W:0] LO = (T_W+1)'(i);
      assign lo_ok = ({1'b0, t} >= LO);
    end

    assign hi_ok  = ({1'b0, t} <= HI);
    assign win[i] = en && lo_ok && hi_ok;
  end

endmodule

// File: rtl/fifo_load_sched.sv
// Load/drain controller for the transpose FIFOs: writes one row per FIFO during
// LOAD, then pops all FIFOs along a skewed window during DRAIN.
module fifo_load_sched
  import tpu_ctrl_pkg::*;
#(
  parameter int DIM   = DIM_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int BITS  = BITS_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   clear,
  input  logic                   row_valid,
  output logic                   row_ready,
  output logic [$clog2(DIM)-1:0] row_idx,
  output logic [DIM-1:0]         wr_en,
  input  logic                   stall,
  output logic [DIM-1:0]         shift_en,
  output logic                   busy,
  output logic                   done
);

  localparam int ROW_W  = cnt_w(DIM);
  localparam int T_W    = cnt_w(DEPTH + DIM - 1);
  localparam int T_LAST = DEPTH + DIM - 2;

  if (DEPTH != DIM) begin : g_bad_depth
    $error("fifo_load_sched: DEPTH must equal DIM");
  end
  if (BITS < 1) begin : g_bad_bits
    $error("fifo_load_sched: BITS must be positive");
  end

  state_e           state_q, state_d;
  logic [ROW_W-1:0] row_cnt_q, row_cnt_d;
  logic [T_W-1:0]   t_q, t_d;
  logic             accept;
  logic             drain_go;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      row_cnt_q <= '0;
      t_q       <= '0;
    end else begin
      state_q   <= state_d;
      row_cnt_q <= row_cnt_d;
      t_q       <= t_d;
    end
  end

  assign row_ready = (state_q == ST_LOAD);
  assign accept    = row_ready && row_valid;
  assign drain_go  = (state_q == ST_DRAIN) && !stall;

  always_comb begin
    state_d   = state_q;
    row_cnt_d = row_cnt_q;
    t_d       = t_q;
    // clear outranks every transition, including a same-cycle start.
    if (clear) begin
      state_d   = ST_IDLE;
      row_cnt_d = '0;
      t_d       = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d   = ST_LOAD;
            row_cnt_d = '0;
            t_d       = '0;
          end
        end
        ST_LOAD: begin
          if (accept) begin
            if (row_cnt_q == ROW_W'(DIM - 1)) begin
              state_d   = ST_DRAIN;
              row_cnt_d = '0;
              t_d       = '0;
            end else begin
              row_cnt_d = row_cnt_q + 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          if (drain_go) begin
            if (t_q == T_W'(T_LAST)) begin
              state_d = ST_DONE;
              t_d     = '0;
            end else begin
              t_d = t_q + 1'b1;
            end
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    wr_en = '0;
    if (accept) wr_en[row_cnt_q] = 1'b1;
  end

  assign row_idx = row_cnt_q;
  assign busy    = (state_q == ST_LOAD) || (state_q == ST_DRAIN);
  assign done    = (state_q == ST_DONE);

  skew_window #(
    .DIM   (DIM),
    .DEPTH (DEPTH),
    .T_W   (T_W)
  ) u_skew_window (
    .t   (t_q),
    .en  (drain_go),
    .win (shift_en)
  );

endmodule

// File: tb/tb_fifo_load_sched.sv
// Scoreboard bench for fifo_load_sched: each pass is planned as a stimulus list,
// expected outputs are queued as stimulus is driven and popped at the falling edge.
module tb_fifo_load_sched;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       clear = 1'b0;
  logic       row_valid = 1'b0;
  logic       stall = 1'b0;
  logic       row_ready;
  logic [2:0] row_idx;
  logic [7:0] wr_en;
  logic [7:0] shift_en;
  logic       busy;
  logic       done;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic       rr;
    logic [2:0] idx;
    logic [7:0] wr;
    logic [7:0] sh;
    logic       busy;
    logic       done;
  } obs_t;

  typedef struct packed {
    logic s;
    logic c;
    logic v;
    logic st;
    obs_t e;
  } step_t;

  obs_t  sb_q[$];
  step_t plan[$];

  localparam logic [7:0] SH_TBL [0:14] = '{
    8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF,
    8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80
  };

  fifo_load_sched #(.DIM(8), .DEPTH(8), .BITS(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .clear     (clear),
    .row_valid (row_valid),
    .row_ready (row_ready),
    .row_idx   (row_idx),
    .wr_en     (wr_en),
    .stall     (stall),
    .shift_en  (shift_en),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  a_busy_needs_start: assert property (@(posedge clk) disable iff (!rst_n)
    $rose(busy) |-> $past(start))
    else $error("FAIL start_ignored: busy rose without a start request");
  a_busy_start_ignored: assert property (@(posedge clk) disable iff (!rst_n)
    (busy && start && !clear) |=> (busy || done))
    else $error("FAIL start_ignored: start while busy disturbed the pass");
  a_done_start_ignored: assert property (@(posedge clk) disable iff (!rst_n)
    (done && start) |=> !busy)
    else $error("FAIL start_ignored: start in DONE began a pass");

  function automatic obs_t mk(input logic rr, input logic [2:0] idx, input logic [7:0] wr,
                              input logic [7:0] sh, input logic b, input logic d);
    obs_t o;
    o.rr = rr; o.idx = idx; o.wr = wr; o.sh = sh; o.busy = b; o.done = d;
    return o;
  endfunction

  function automatic obs_t cur();
    return mk(row_ready, row_idx, wr_en, shift_en, busy, done);
  endfunction

  // Plans and runs one pass. gap: row_valid only on alternate LOAD cycles.
  // stall_at/stall_len: stalled cycles inserted when t reaches stall_at.
  // poke: start held high in every busy/DONE cycle. clear_at: abort at that t.
  task automatic run_pass(input string nm, input bit gap, input int stall_at,
                          input int stall_len, input bit poke, input int clear_at);
    step_t p;
    obs_t  e, o;
    int    k, ph, t, sl, dr;
    int    wr_cnt[8];
    int    sh_cnt[8];
    bit    aborted;
    aborted = 1'b0;
    plan.delete();
    plan.push_back('{1'b1, 1'b0, 1'b0, 1'b0, mk(0, 3'd0, 8'h00, 8'h00, 0, 0)});
    k = 0; ph = 0;
    while (k < 8) begin
      if (gap && ph[0]) begin
        plan.push_back('{poke, 1'b0, 1'b0, 1'b0, mk(1, k[2:0], 8'h00, 8'h00, 1, 0)});
      end else begin
        plan.push_back('{poke, 1'b0, 1'b1, 1'b0, mk(1, k[2:0], 8'(1 << k), 8'h00, 1, 0)});
        k++;
      end
      ph++;
    end
    t = 0; sl = stall_len;
    while (t < 15 && !aborted) begin
      if (t == clear_at) begin
        plan.push_back('{1'b0, 1'b1, 1'b0, 1'b0, mk(0, 3'd0, 8'h00, SH_TBL[t], 1, 0)});
        aborted = 1'b1;
      end else if (t == stall_at && sl > 0) begin
        plan.push_back('{poke, 1'b0, 1'b0, 1'b1, mk(0, 3'd0, 8'h00, 8'h00, 1, 0)});
        sl--;
      end else begin
        plan.push_back('{poke, 1'b0, 1'b0, 1'b0, mk(0, 3'd0, 8'h00, SH_TBL[t], 1, 0)});
        t++;
      end
    end
    if (!aborted) plan.push_back('{poke, 1'b0, 1'b0, 1'b0, mk(0, 3'd0, 8'h00, 8'h00, 0, 1)});
    plan.push_back('{1'b0, 1'b0, 1'b0, 1'b0, mk(0, 3'd0, 8'h00, 8'h00, 0, 0)});
    plan.push_back('{1'b0, 1'b0, 1'b0, 1'b0, mk(0, 3'd0, 8'h00, 8'h00, 0, 0)});

    dr = 0;
    for (int i = 0; i < 8; i++) begin wr_cnt[i] = 0; sh_cnt[i] = 0; end
    while (plan.size() > 0) begin
      p = plan.pop_front();
      @(posedge clk); #1;
      start = p.s; clear = p.c; row_valid = p.v; stall = p.st;
      sb_q.push_back(p.e);
      @(negedge clk);
      o = cur();
      e = sb_q.pop_front();
      tests++;
      if (o !== e) begin
        fails++;
        $display("FAIL %s: got rr=%b idx=%0d wr=%h sh=%h busy=%b done=%b, expected rr=%b idx=%0d wr=%h sh=%h busy=%b done=%b",
                 nm, o.rr, o.idx, o.wr, o.sh, o.busy, o.done, e.rr, e.idx, e.wr, e.sh, e.busy, e.done);
      end
      tests++;
      if ((|wr_en) && (|shift_en)) begin
        fails++;
        $display("FAIL %s_overlap: wr=%h sh=%h both active, expected at most one", nm, wr_en, shift_en);
      end
      for (int i = 0; i < 8; i++) begin
        wr_cnt[i] += int'(wr_en[i]);
        sh_cnt[i] += int'(shift_en[i]);
      end
      if (busy && !row_ready) dr++;
    end
    start = 1'b0; clear = 1'b0; row_valid = 1'b0; stall = 1'b0;

    if (!aborted) begin
      for (int i = 0; i < 8; i++) begin
        tests++;
        if (wr_cnt[i] !== 1 || sh_cnt[i] !== 8) begin
          fails++;
          $display("FAIL %s_fifo%0d_pulses: got wr=%0d shift=%0d, expected wr=1 shift=8",
                   nm, i, wr_cnt[i], sh_cnt[i]);
        end
      end
      tests++;
      if (dr !== 15 + stall_len) begin
        fails++;
        $display("FAIL %s_drain_len: got %0d cycles, expected %0d", nm, dr, 15 + stall_len);
      end
    end
  endtask

  task automatic test_reset();
    #2;
    tests++;
    if (cur() !== mk(0, 3'd0, 8'h00, 8'h00, 0, 0)) begin
      fails++;
      $display("FAIL reset_outputs: got %h, expected all zero", cur());
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    tests++;
    if (cur() !== mk(0, 3'd0, 8'h00, 8'h00, 0, 0)) begin
      fails++;
      $display("FAIL post_reset_idle: got %h, expected all zero", cur());
    end
  endtask

  task automatic test_basic();
    run_pass("basic", 1'b0, -1, 0, 1'b0, -1);
  endtask

  task automatic test_stall();
    run_pass("stall", 1'b0, 4, 3, 1'b0, -1);
  endtask

  task automatic test_row_gaps();
    run_pass("row_gaps", 1'b1, -1, 0, 1'b0, -1);
  endtask

  task automatic test_start_ignored();
    run_pass("start_ignored", 1'b1, 2, 2, 1'b1, -1);
  endtask

  task automatic test_clear();
    run_pass("clear_drain", 1'b0, -1, 0, 1'b0, 5);
    @(posedge clk); #1;
    start = 1'b1; clear = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; clear = 1'b0;
    @(negedge clk);
    tests++;
    if (busy !== 1'b0 || row_ready !== 1'b0) begin
      fails++;
      $display("FAIL clear_with_start: got busy=%b rr=%b, expected busy=0 rr=0", busy, row_ready);
    end
    run_pass("after_clear", 1'b0, -1, 0, 1'b0, -1);
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; row_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (row_idx !== 3'd3 || wr_en !== 8'h08) begin
      fails++;
      $display("FAIL reset_mid_setup: got idx=%0d wr=%h, expected idx=3 wr=08", row_idx, wr_en);
    end
    rst_n = 1'b0;
    #1;
    tests++;
    if (cur() !== mk(0, 3'd0, 8'h00, 8'h00, 0, 0)) begin
      fails++;
      $display("FAIL reset_mid_outputs: got %h, expected all zero", cur());
    end
    row_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run_pass("after_reset", 1'b0, -1, 0, 1'b0, -1);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_row_gaps();
    test_start_ignored();
    test_clear();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/fifo_load_sched.md
FIFO_LOAD_SCHED -- requirements
Module: fifo_load_sched

Interface
REQ-001 Parameter DIM, 8, number of transpose FIFOs (one per systolic row/column).
REQ-002 Parameter DEPTH, 8, entries per FIFO; SHALL equal DIM, elaboration error otherwise.
REQ-003 Parameter BITS, 8, element width; carried for package consistency, unused by control logic.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 start  input  1  one-cycle request to begin a load/drain pass; honoured only in IDLE.
REQ-007 clear  input  1  synchronous abort; returns to IDLE next cycle from any state.
REQ-008 row_valid  input  1  upstream row of DIM elements present on the FIFO data bus.
REQ-009 row_ready  output  1  controller accepts the row this cycle.
REQ-010 row_idx  output  $clog2(DIM)  index of the FIFO receiving the current row.
REQ-011 wr_en  output  DIM  one-hot write strobe, bit i to FIFO i WrEn.
REQ-012 stall  input  1  downstream array stall; freezes drain progress.
REQ-013 shift_en  output  DIM  per-FIFO pop strobe, bit i to FIFO i en.
REQ-014 busy  output  1  high in LOAD and DRAIN.
REQ-015 done  output  1  one-cycle pulse at pass completion.

Function
REQ-016 States: IDLE, LOAD, DRAIN, DONE; encoded as the package enum.
REQ-017 IDLE -> LOAD on start; start in any other state SHALL be ignored.
REQ-018 LOAD: row_ready=1; row_idx=row_cnt; wr_en[row_cnt]=row_valid&row_ready, combinational, all other bits 0.
REQ-019 Each accepted row increments row_cnt; acceptance with row_cnt==DIM-1 SHALL transition to DRAIN next cycle, row_cnt cleared.
REQ-020 row_valid low in LOAD: no strobe, row_cnt holds, no timeout.
REQ-021 DRAIN: drain counter t starts at 0; shift_en[i]=1 iff i<=t<=i+DEPTH-1 and stall==0.
REQ-022 t increments each non-stalled DRAIN cycle; stall holds t and forces shift_en=0.
REQ-023 Non-stalled cycle with t==DEPTH+DIM-2 SHALL transition to DONE; drain therefore spans exactly DEPTH+DIM-1 non-stalled cycles.
REQ-024 DONE: done=1 for exactly one cycle, then IDLE; start in DONE ignored.
REQ-025 wr_en and shift_en SHALL never be nonzero in the same cycle.
REQ-026 Each FIFO SHALL receive exactly DEPTH shift_en pulses and one wr_en pulse per pass.
REQ-027 row_ready, wr_en, shift_en SHALL be 0 outside LOAD/DRAIN respectively.
REQ-028 clear has priority over all transitions; next cycle state=IDLE, counters 0, all outputs 0; clear in same cycle as start SHALL leave state IDLE.

Reset
REQ-029 rst_n low: state=IDLE, row_cnt=0, t=0 asynchronously.
REQ-030 During and after reset: row_ready, wr_en, shift_en, busy, done, row_idx all 0.
REQ-031 Reset mid-pass abandons the pass with no done pulse; next start begins a fresh LOAD.

Structure
REQ-032 Shared package tpu_ctrl_pkg SHALL hold the state enum, DIM/DEPTH defaults and counter-width constants.
REQ-033 One sub-module skew_window SHALL decode t into the DIM-bit shift_en window; remaining logic stays in fifo_load_sched.
REQ-034 Outputs wr_en/row_ready combinational from state and handshake; shift_en/busy/done derived from registered state and counters.

Verification
REQ-035 Reset then start, row_valid held high 8 cycles -> wr_en = 0x01,0x02,...,0x80 on consecutive cycles, then DRAIN.
REQ-036 Unstalled drain -> shift_en: t=0 0x01, t=1 0x03, t=7 0xFF, t=8 0xFE, t=14 0x80; done pulses one cycle after t=14.
REQ-037 stall asserted at t=4 for 3 cycles -> shift_en=0, t holds at 4, pattern resumes 0x1F; total drain 18 cycles.
REQ-038 row_valid gaps (valid every other cycle) -> row_idx advances only on accepted rows; 8 strobes total, drain begins after 8th.
REQ-039 clear at t=5 in DRAIN -> next cycle IDLE, all outputs 0, no done; subsequent start yields full correct pass.
REQ-040 rst_n low during LOAD at row_cnt=3 -> outputs 0 immediately; start pulse while busy ignored, checked by an assertion.
